// File: rtl/rx_serial_ov7670.sv
// UART-style receiver (8N1, LSB first) for bytes returned by the camera-side MCU.
// Define RX_PARIDADE_EN to build the 8E1 variant with an even-parity check.
module rx_serial_ov7670 #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       RX,
   output logic [7:0] dado_recebido,
   output logic       fim_recepcao,
   output logic       erro_recepcao,
   output logic       ocupado,
   output logic [3:0] db_estado
);

   localparam int CPB   = CLK_HZ / BAUD;
   localparam int HALF  = CPB / 2;
   localparam int CNT_W = $clog2(CPB);

   typedef enum logic [2:0] {
      st_ocioso   = 3'd0,
      st_start    = 3'd1,
      st_dados    = 3'd2,
`ifdef RX_PARIDADE_EN
      st_paridade = 3'd3,
`endif
      st_stop     = 3'd4,
      st_final    = 3'd5,
      st_erro     = 3'd6
   } state_t;

   state_t           state_reg, state_next;
   logic [1:0]       sync_reg;
   logic             rx_s;
   logic [CNT_W-1:0] counter_reg;
   logic [2:0]       ibit_reg;
   logic [7:0]       shift_reg;
   logic [7:0]       dado_reg;
   logic             fim_reg;
   logic             erro_reg;
   logic             tick_half;
   logic             tick_bit;
   logic             stop_ok;

   // Synchronizer idles high so a reset never looks like a start edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_reg <= 2'b11;
      else       sync_reg <= {sync_reg[0], RX};
   end
   assign rx_s = sync_reg[1];

   assign tick_half = (counter_reg == CNT_W'(HALF - 1));
   assign tick_bit  = (counter_reg == CNT_W'(CPB - 1));

`ifdef RX_PARIDADE_EN
   logic par_err_reg;
   assign stop_ok = rx_s && !par_err_reg;
`else
   assign stop_ok = rx_s;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_reg <= st_ocioso;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         st_ocioso:   if (!rx_s) state_next = st_start;
         st_start:    if (tick_half) state_next = rx_s ? st_ocioso : st_dados;
`ifdef RX_PARIDADE_EN
         st_dados:    if (tick_bit && ibit_reg == 3'd7) state_next = st_paridade;
         st_paridade: if (tick_bit) state_next = st_stop;
`else
         st_dados:    if (tick_bit && ibit_reg == 3'd7) state_next = st_stop;
`endif
         st_stop:     if (tick_bit) state_next = stop_ok ? st_final : st_erro;
         st_final:    state_next = st_ocioso;
         st_erro:     if (rx_s) state_next = st_ocioso;
         default:     state_next = st_ocioso;
      endcase
   end

   // Pulses are registered on the stop-bit decision so fim_recepcao coincides
   // with the first cycle in which dado_recebido shows the new byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         counter_reg <= '0;
         ibit_reg    <= 3'd0;
         shift_reg   <= 8'h00;
         dado_reg    <= 8'h00;
         fim_reg     <= 1'b0;
         erro_reg    <= 1'b0;
`ifdef RX_PARIDADE_EN
         par_err_reg <= 1'b0;
`endif
      end else begin
         fim_reg  <= 1'b0;
         erro_reg <= 1'b0;
         case (state_reg)
            st_start: begin
               if (tick_half) begin
                  counter_reg <= '0;
                  ibit_reg    <= 3'd0;
               end else begin
                  counter_reg <= counter_reg + 1'b1;
               end
            end
            st_dados: begin
               if (tick_bit) begin
                  counter_reg <= '0;
                  shift_reg   <= {rx_s, shift_reg[7:1]};
                  if (ibit_reg != 3'd7) ibit_reg <= ibit_reg + 3'd1;
               end else begin
                  counter_reg <= counter_reg + 1'b1;
               end
            end
`ifdef RX_PARIDADE_EN
            st_paridade: begin
               if (tick_bit) begin
                  counter_reg <= '0;
                  par_err_reg <= ^{shift_reg, rx_s};
               end else begin
                  counter_reg <= counter_reg + 1'b1;
               end
            end
`endif
            st_stop: begin
               if (tick_bit) begin
                  counter_reg <= '0;
                  if (stop_ok) begin
                     dado_reg <= shift_reg;
                     fim_reg  <= 1'b1;
                  end else begin
                     erro_reg <= 1'b1;
                  end
               end else begin
                  counter_reg <= counter_reg + 1'b1;
               end
            end
            default: begin
               counter_reg <= '0;
`ifdef RX_PARIDADE_EN
               if (state_reg == st_ocioso) par_err_reg <= 1'b0;
`endif
            end
         endcase
      end
   end

   always_comb begin
      db_estado = 4'b1111;
      case (state_reg)
         st_ocioso:   db_estado = 4'b0000;
         st_start:    db_estado = 4'b0001;
         st_dados:    db_estado = 4'b0010;
`ifdef RX_PARIDADE_EN
         st_paridade: db_estado = 4'b0011;
`endif
         st_stop:     db_estado = 4'b0100;
         st_final:    db_estado = 4'b0101;
         st_erro:     db_estado = 4'b0110;
         default:     db_estado = 4'b1111;
      endcase
   end

   assign ocupado       = (state_reg != st_ocioso);
   assign dado_recebido = dado_reg;
   assign fim_recepcao  = fim_reg;
   assign erro_recepcao = erro_reg;

endmodule

// File: tb/tb_rx_serial_ov7670.sv
// Directed bench for rx_serial_ov7670 at CPB=10: frames are scored against an
// expected-pulse queue (kind, byte, cycle) filled when each frame is driven.
module tb_rx_serial_ov7670;

   localparam int CPB  = 10;
   localparam int HALF = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       RX    = 1'b1;
   logic [7:0] dado_recebido;
   logic       fim_recepcao;
   logic       erro_recepcao;
   logic       ocupado;
   logic [3:0] db_estado;

   typedef struct {
      bit         kind;   // 0 = good byte, 1 = error pulse
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_good = 8'h00;

   rx_serial_ov7670 #(.CLK_HZ(1000), .BAUD(100)) dut (
      .clock         (clock),
      .reset         (reset),
      .RX            (RX),
      .dado_recebido (dado_recebido),
      .fim_recepcao  (fim_recepcao),
      .erro_recepcao (erro_recepcao),
      .ocupado       (ocupado),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      RX = b;
      repeat (CPB) @(posedge clock);
      #1;
   endtask

   // Pin edge at cycle n -> E = n+2; pulse at E+HALF+9*CPB+1 (+CPB with parity).
   task automatic send_frame(input logic [7:0] d, input bit with_par,
                             input logic par_bit, input logic stop_bit);
      exp_t e;
      e.kind = !(stop_bit && (!with_par || ((^d ^ par_bit) == 1'b0)));
      e.data = d;
      e.cyc  = cyc + 2 + HALF + 9 * CPB + 1 + (with_par ? CPB : 0);
      sb.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (with_par) drive_bit(par_bit);
      drive_bit(stop_bit);
   endtask

   task automatic wait_cycle(input int target);
      @(negedge clock);
      while (cyc < target) @(negedge clock);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (fim_recepcao || erro_recepcao) begin
            exp_t e;
            chk("pulse_exclusive", {31'd0, fim_recepcao & erro_recepcao}, 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_pulse observed fim=%0b erro=%0b expected none at cycle %0d",
                      fim_recepcao, erro_recepcao, cyc);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("pulse_kind", {31'd0, erro_recepcao}, {31'd0, e.kind});
               chk("pulse_cycle", cyc, e.cyc);
               if (!e.kind) begin
                  chk("byte_value", dado_recebido, e.data);
                  last_good = e.data;
               end else begin
                  chk("byte_held_on_error", dado_recebido, last_good);
               end
               $display("frame data=%02h kind=%0d cycle=%0d dado=%02h", e.data, e.kind, cyc, dado_recebido);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_dado", dado_recebido, 8'h00);
      chk("rst_fim", {31'd0, fim_recepcao}, 32'd0);
      chk("rst_erro", {31'd0, erro_recepcao}, 32'd0);
      chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
      chk("rst_db", db_estado, 4'b0000);
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (5) @(posedge clock); #1;

      // Single 8N1 byte
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      repeat (5) @(posedge clock); #1;
      chk("a5_held", dado_recebido, 8'hA5);
      chk("a5_idle", db_estado, 4'b0000);

      // Back-to-back frames without an idle gap
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      repeat (5) @(posedge clock); #1;

      // Short glitch: start sample at E+5 sees high, idle again the cycle after
      n = cyc;
      RX = 1'b0;
      repeat (3) @(posedge clock); #1;
      RX = 1'b1;
      wait_cycle(n + 2 + 2);
      chk("glitch_in_start", db_estado, 4'b0001);
      wait_cycle(n + 2 + HALF + 1);
      chk("glitch_idle", db_estado, 4'b0000);
      chk("glitch_ocupado", {31'd0, ocupado}, 32'd0);
      chk("glitch_dado", dado_recebido, 8'hFF);
      repeat (10) @(posedge clock); #1;

      // Stop bit low, line held low for 50 cycles
      n = cyc;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      RX = 1'b0;
      wait_cycle(n + 110);
      chk("erro_state", db_estado, 4'b0110);
      chk("erro_ocupado", {31'd0, ocupado}, 32'd0 + 1);
      chk("erro_dado", dado_recebido, 8'hFF);
      wait_cycle(n + 100 + 45);
      chk("erro_state_late", db_estado, 4'b0110);
      @(posedge clock); #1;
      RX = 1'b1;
      repeat (5) @(posedge clock); #1;
      chk("erro_exit", db_estado, 4'b0000);
      chk("erro_dado_after", dado_recebido, 8'hFF);

      // Reset during bit 4 of 0x81: partial byte dropped, no pulse
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i == 0);
      RX = 1'b0;
      repeat (3) @(posedge clock); #1;
      chk("pre_reset_dados", db_estado, 4'b0010);
      reset = 1'b1;
      #1;
      chk("midrst_dado", dado_recebido, 8'h00);
      chk("midrst_fim", {31'd0, fim_recepcao}, 32'd0);
      chk("midrst_erro", {31'd0, erro_recepcao}, 32'd0);
      chk("midrst_ocupado", {31'd0, ocupado}, 32'd0);
      chk("midrst_db", db_estado, 4'b0000);
      last_good = 8'h00;
      @(posedge clock); #1;
      reset = 1'b0;
      RX = 1'b1;
      repeat (20) @(posedge clock); #1;
      send_frame(8'h42, 1'b0, 1'b0, 1'b1);
      repeat (5) @(posedge clock); #1;
      chk("after_reset_byte", dado_recebido, 8'h42);

`ifdef RX_PARIDADE_EN
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      repeat (5) @(posedge clock); #1;
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      repeat (5) @(posedge clock); #1;
      chk("parity_err_held", dado_recebido, 8'h07);
`endif

      repeat (20) @(posedge clock); #1;
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
